// File: rtl/prime_round_sched_pkg.sv
// Shared types and constants for the prime-prediction round scheduler.
package prime_game_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_RNG,
    TURN,
    VERIFY,
    WAIT_RES,
    SCORE,
    DONE
  } state_t;

  localparam logic [1:0] P_NONE = 2'b00;
  localparam logic [1:0] P1     = 2'b01;
  localparam logic [1:0] P2     = 2'b10;
  localparam logic [1:0] P_TIE  = 2'b11;

  // Winner code from the two final scores.
  function automatic logic [1:0] pick_winner(input int unsigned s1, input int unsigned s2);
    if (s1 > s2)      return P1;
    else if (s2 > s1) return P2;
    else              return P_TIE;
  endfunction

endpackage

// File: rtl/prime_round_sched_if.sv
// Handshakes between the scheduler, the RNG block and the shared verifier.
interface prime_round_sched_if;
  logic rng_req;
  logic rng_rdy;
  logic vfy_start;
  logic vfy_done;
  logic vfy_prime;

  modport master (
    output rng_req, vfy_start,
    input  rng_rdy, vfy_done, vfy_prime
  );

  modport slave (
    input  rng_req, vfy_start,
    output rng_rdy, vfy_done, vfy_prime
  );
endinterface

// File: rtl/prime_round_sched_rr_arb2.sv
// Two-way round-robin arbiter; the pointer remembers the last granted player
// and resets to P2 so that P1 wins the first simultaneous request.
module rr_arb2
  import prime_game_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] grant
);

  logic last_p2;

  // Grant the sole requester, or the player not granted last time on a tie.
  always_comb begin
    grant = P_NONE;
    unique case (req)
      2'b01:   grant = P1;
      2'b10:   grant = P2;
      2'b11:   grant = last_p2 ? P1 : P2;
      default: grant = P_NONE;
    endcase
  end

  // Track the last granted player.
  always_ff @(posedge clk) begin
    if (!rst)                           last_p2 <= 1'b1;
    else if (en && (grant != P_NONE))   last_p2 <= grant[1];
  end

endmodule

// File: rtl/prime_round_sched.sv
// Round scheduler for the prime-prediction game: requests a random number,
// arbitrates the guess, launches the shared verifier and keeps score.
// Optional turn timeout enabled by defining PRIME_TURN_TIMEOUT_EN.
module prime_round_sched
  import prime_game_pkg::*;
#(
  parameter int unsigned ROUNDS   = 8,
  parameter int unsigned SCORE_W  = 4,
  parameter int unsigned TURN_TMO = 200
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                p1_btn,
  input  logic                p2_btn,
  prime_round_sched_if.master bus,
  output logic [1:0]          turn_owner,
  output logic [SCORE_W-1:0]  p1_score,
  output logic [SCORE_W-1:0]  p2_score,
  output logic [7:0]          round_cnt,
  output logic                game_over,
  output logic [1:0]          winner
);

  state_t               state, state_nxt;
  logic [1:0]           grant;
  logic                 prime_q;
  logic                 tmo_hit;
  logic                 last_round;
  logic                 p1_gain, p2_gain;
  logic [SCORE_W-1:0]   p1_nxt, p2_nxt;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   ({p2_btn, p1_btn}),
    .en    (state == TURN),
    .grant (grant)
  );

`ifdef PRIME_TURN_TIMEOUT_EN
  localparam int unsigned TMO_W = (TURN_TMO > 1) ? $clog2(TURN_TMO) : 1;
  logic [TMO_W-1:0] tmo_cnt;

  // Count cycles spent in TURN; restarts on every entry.
  always_ff @(posedge clk) begin
    if (!rst || (state != TURN)) tmo_cnt <= '0;
    else                         tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign tmo_hit = (state == TURN) && (tmo_cnt == TMO_W'(TURN_TMO - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  assign bus.rng_req   = (state == REQ);
  assign bus.vfy_start = (state == VERIFY);
  assign game_over     = (state == DONE);
  assign last_round    = (round_cnt == 8'(ROUNDS - 1));

  // Score update for the SCORE cycle; a forfeited round has no owner, so no gain.
  always_comb begin
    p1_gain = ((turn_owner == P1) &&  prime_q) || ((turn_owner == P2) && !prime_q);
    p2_gain = ((turn_owner == P2) &&  prime_q) || ((turn_owner == P1) && !prime_q);
    p1_nxt  = (p1_gain && (p1_score != '1)) ? p1_score + 1'b1 : p1_score;
    p2_nxt  = (p2_gain && (p2_score != '1)) ? p2_score + 1'b1 : p2_score;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (start) state_nxt = REQ;
      REQ:      state_nxt = WAIT_RNG;
      WAIT_RNG: if (bus.rng_rdy) state_nxt = TURN;
      TURN: begin
        if (grant != P_NONE) state_nxt = VERIFY;
        else if (tmo_hit)    state_nxt = SCORE;
      end
      VERIFY:   state_nxt = WAIT_RES;
      WAIT_RES: if (bus.vfy_done) state_nxt = SCORE;
      SCORE:    state_nxt = last_round ? DONE : REQ;
      DONE:     if (!start) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Game datapath: owner, registered result, scores, round count, winner.
  always_ff @(posedge clk) begin
    if (!rst) begin
      turn_owner <= P_NONE;
      prime_q    <= 1'b0;
      p1_score   <= '0;
      p2_score   <= '0;
      round_cnt  <= '0;
      winner     <= P_NONE;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            p1_score  <= '0;
            p2_score  <= '0;
            round_cnt <= '0;
            winner    <= P_NONE;
          end
        end
        TURN:     if (grant != P_NONE) turn_owner <= grant;
        WAIT_RES: if (bus.vfy_done) prime_q <= bus.vfy_prime;
        SCORE: begin
          p1_score   <= p1_nxt;
          p2_score   <= p2_nxt;
          round_cnt  <= round_cnt + 8'd1;
          turn_owner <= P_NONE;
          if (last_round) winner <= pick_winner(32'(p1_nxt), 32'(p2_nxt));
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prime_round_sched.sv
// Self-checking bench for prime_round_sched with a round-level reference model.
module tb_prime_round_sched;

  localparam int ROUNDS   = 6;
  localparam int SCORE_W  = 2;
  localparam int TURN_TMO = 5;
  localparam int MAXS     = (1 << SCORE_W) - 1;

  logic clk = 1'b0;
  logic rst, start, p1_btn, p2_btn;
  logic [1:0]         turn_owner, winner;
  logic [SCORE_W-1:0] p1_score, p2_score;
  logic [7:0]         round_cnt;
  logic               game_over;

  prime_round_sched_if bus ();

  prime_round_sched #(.ROUNDS(ROUNDS), .SCORE_W(SCORE_W), .TURN_TMO(TURN_TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .p1_btn     (p1_btn),
    .p2_btn     (p2_btn),
    .bus        (bus),
    .turn_owner (turn_owner),
    .p1_score   (p1_score),
    .p2_score   (p2_score),
    .round_cnt  (round_cnt),
    .game_over  (game_over),
    .winner     (winner)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_p1, m_p2, m_rc, m_last, m_owner, m_vfy, m_rng;
  int pat_tbl [ROUNDS];
  bit pr_tbl  [ROUNDS];

  // Observed pulse counts
  int   rng_cnt = 0, vfy_cnt = 0;
  logic prev_rng = 1'b0, prev_vfy = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    if (bus.rng_req === 1'b1) begin
      rng_cnt++;
      check("rng_req_b2b", 32'(prev_rng), 0);
    end
    if (bus.vfy_start === 1'b1) begin
      vfy_cnt++;
      check("vfy_start_b2b", 32'(prev_vfy), 0);
    end
    prev_rng = bus.rng_req;
    prev_vfy = bus.vfy_start;
  end

  task automatic step();
    @(negedge clk);
  endtask

  function automatic int sat(input int v);
    return (v >= MAXS) ? MAXS : v + 1;
  endfunction

  function automatic int exp_winner(input int a, input int b);
    return (a > b) ? 1 : (b > a) ? 2 : 3;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_owner"},  32'(turn_owner), 0);
    check({tag, "_p1"},     32'(p1_score), 0);
    check({tag, "_p2"},     32'(p2_score), 0);
    check({tag, "_rcnt"},   32'(round_cnt), 0);
    check({tag, "_over"},   32'(game_over), 0);
    check({tag, "_winner"}, 32'(winner), 0);
    check({tag, "_rngreq"}, 32'(bus.rng_req), 0);
    check({tag, "_vfy"},    32'(bus.vfy_start), 0);
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    m_p1 = 0; m_p2 = 0; m_rc = 0;
    check("start_rng_req", 32'(bus.rng_req), 1);
    m_rng++;
    check("start_p1_clr", 32'(p1_score), 0);
    check("start_p2_clr", 32'(p2_score), 0);
    check("start_rcnt_clr", 32'(round_cnt), 0);
    check("start_winner_clr", 32'(winner), 0);
  endtask

  // From REQ: wait out a random RNG delay, then land in TURN.
  task automatic do_rng();
    step();
    repeat ($urandom_range(0, 3)) step();
    bus.rng_rdy = 1'b1;
    step();
    bus.rng_rdy = 1'b0;
  endtask

  task automatic do_turn(input int pat);
    int g;
    repeat ($urandom_range(0, 3)) step();
    {p2_btn, p1_btn} = 2'(pat);
    step();
    p1_btn = 1'b0; p2_btn = 1'b0;
    g = (pat == 3) ? ((m_last == 1) ? 2 : 1) : pat;
    m_last = g; m_owner = g; m_vfy++;
    check("turn_owner", 32'(turn_owner), 32'(g));
    check("vfy_start", 32'(bus.vfy_start), 1);
  endtask

  task automatic finish_round();
    m_rc++;
    check("p1_score", 32'(p1_score), 32'(m_p1));
    check("p2_score", 32'(p2_score), 32'(m_p2));
    check("round_cnt", 32'(round_cnt), 32'(m_rc));
    check("owner_clear", 32'(turn_owner), 0);
    if (m_rc == ROUNDS) begin
      check("game_over", 32'(game_over), 1);
      check("winner", 32'(winner), 32'(exp_winner(m_p1, m_p2)));
      check("no_rng_at_done", 32'(bus.rng_req), 0);
    end else begin
      check("next_rng_req", 32'(bus.rng_req), 1);
      check("winner_pending", 32'(winner), 0);
      m_rng++;
    end
  endtask

  task automatic do_verify(input bit prime);
    step();
    check("vfy_single", 32'(bus.vfy_start), 0);
    repeat ($urandom_range(0, 3)) begin
      {p2_btn, p1_btn} = 2'($urandom_range(0, 3));
      bus.rng_rdy = 1'($urandom_range(0, 1));
      step();
    end
    p1_btn = 1'b0; p2_btn = 1'b0; bus.rng_rdy = 1'b0;
    bus.vfy_done = 1'b1; bus.vfy_prime = prime;
    step();
    bus.vfy_done = 1'b0; bus.vfy_prime = 1'($urandom_range(0, 1));
    check("owner_hold", 32'(turn_owner), 32'(m_owner));
    if (prime) begin
      if (m_owner == 1) m_p1 = sat(m_p1); else m_p2 = sat(m_p2);
    end else begin
      if (m_owner == 1) m_p2 = sat(m_p2); else m_p1 = sat(m_p1);
    end
    step();
    finish_round();
  endtask

  task automatic do_idle_turn();
`ifdef PRIME_TURN_TIMEOUT_EN
    repeat (TURN_TMO + 1) step();
    check("tmo_no_vfy", 32'(bus.vfy_start), 0);
    finish_round();
`else
    repeat (4 * TURN_TMO) step();
    check("wait_owner", 32'(turn_owner), 0);
    check("wait_rcnt", 32'(round_cnt), 32'(m_rc));
    check("wait_no_vfy", 32'(bus.vfy_start), 0);
    do_turn(1 + $urandom_range(0, 2));
    do_verify(1'($urandom_range(0, 1)));
`endif
  endtask

  // pat 0 = leave the turn idle; otherwise button pattern {p2,p1}.
  task automatic play_game();
    do_start();
    for (int r = 0; r < ROUNDS; r++) begin
      do_rng();
      if (pat_tbl[r] == 0) begin
        do_idle_turn();
      end else begin
        do_turn(pat_tbl[r]);
        do_verify(pr_tbl[r]);
      end
    end
    repeat (2) step();
    check("done_hold", 32'(game_over), 1);
    start = 1'b0;
    step();
    check("idle_over", 32'(game_over), 0);
    check("idle_winner_hold", 32'(winner), 32'(exp_winner(m_p1, m_p2)));
    check("idle_p1_hold", 32'(p1_score), 32'(m_p1));
    check("idle_p2_hold", 32'(p2_score), 32'(m_p2));
    check("vfy_count", 32'(vfy_cnt), 32'(m_vfy));
    check("rng_count", 32'(rng_cnt), 32'(m_rng));
  endtask

  task automatic set_tbl(input int p0, p1, p2, p3, p4, p5, input bit [5:0] pr);
    pat_tbl[0] = p0; pat_tbl[1] = p1; pat_tbl[2] = p2;
    pat_tbl[3] = p3; pat_tbl[4] = p4; pat_tbl[5] = p5;
    for (int i = 0; i < ROUNDS; i++) pr_tbl[i] = pr[i];
  endtask

  task automatic rand_tbl();
    for (int i = 0; i < ROUNDS; i++) begin
      pat_tbl[i] = $urandom_range(1, 3);
      pr_tbl[i]  = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; p1_btn = 1'b0; p2_btn = 1'b0;
    bus.rng_rdy = 1'b0; bus.vfy_done = 1'b0; bus.vfy_prime = 1'b0;
    m_last = 2; m_vfy = 0; m_rng = 0; m_p1 = 0; m_p2 = 0; m_rc = 0; m_owner = 0;
    repeat (3) step();
    check_all_zero("rst");
    rst = 1'b1;
    step();

    // Simultaneous presses alternate; wrong guesses credit the opponent.
    set_tbl(3, 3, 1, 2, 1, 2, 6'b011011);
    play_game();
    // P1 always right: score saturates.
    set_tbl(1, 1, 1, 1, 1, 1, 6'b111111);
    play_game();
    // Alternating correct guesses end in a tie.
    set_tbl(1, 2, 1, 2, 1, 2, 6'b111111);
    play_game();
    // Idle turn in the first round.
    rand_tbl();
    pat_tbl[0] = 0;
    play_game();
    for (int g = 0; g < 3; g++) begin
      rand_tbl();
      play_game();
    end

    // Reset while waiting for the verifier.
    do_start();
    do_rng();
    do_turn(2);
    step();
    rst = 1'b0; start = 1'b0;
    repeat (2) step();
    check_all_zero("midrst");
    rst = 1'b1;
    m_last = 2;
    repeat (4) step();
    check("post_rst_rng", 32'(bus.rng_req), 0);
    check("post_rst_vfy", 32'(bus.vfy_start), 0);
    check("post_rst_vfy_count", 32'(vfy_cnt), 32'(m_vfy));

    // Pointer back to favouring P1 after reset.
    rand_tbl();
    pat_tbl[0] = 3;
    play_game();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
